// File: rtl/dice_roller.sv
// rtl/dice_roller.sv - debounced roll button driving two spinning mod-6 dice
// Optional DICE_LFSR_EN: s2 steps on an 8-bit LFSR bit instead of the s1 wrap.
module dice_roller #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       roll_n,
  output logic       roll_valid,
  output logic [2:0] die1,
  output logic [2:0] die2,
  output logic [3:0] sum,
  output logic       spinning,
  output logic [7:0] roll_count
);

  localparam logic [2:0] S_IDLE         = 3'd0;
  localparam logic [2:0] S_PRESS_WAIT   = 3'd1;
  localparam logic [2:0] S_SPIN         = 3'd2;
  localparam logic [2:0] S_RELEASE_WAIT = 3'd3;
  localparam logic [2:0] S_DONE         = 3'd4;

  localparam logic [19:0] CNT_LAST = 20'(DEBOUNCE_CYCLES - 1);

  logic        p_meta;
  logic        p_s;
  logic [2:0]  state;
  logic [19:0] cnt;
  logic [2:0]  s1;
  logic [2:0]  s2;
  logic        s2_step;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      p_meta <= 1'b0;
      p_s    <= 1'b0;
    end else begin
      p_meta <= ~roll_n;
      p_s    <= p_meta;
    end
  end

`ifdef DICE_LFSR_EN
  logic [7:0] lfsr;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lfsr <= 8'h01;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  assign s2_step = lfsr[0];
`else
  assign s2_step = (s1 == 3'd6);
`endif

  // Spin counters persist across rolls; only reset clears them.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1 <= 3'd1;
      s2 <= 3'd1;
    end else if (state == S_SPIN) begin
      s1 <= (s1 == 3'd6) ? 3'd1 : s1 + 3'd1;
      if (s2_step) begin
        s2 <= (s2 == 3'd6) ? 3'd1 : s2 + 3'd1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= 20'd0;
      die1       <= 3'd1;
      die2       <= 3'd1;
      sum        <= 4'd2;
      roll_count <= 8'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (p_s) begin
            state <= S_PRESS_WAIT;
            cnt   <= 20'd0;
          end
        end
        S_PRESS_WAIT: begin
          if (!p_s) begin
            state <= S_IDLE;
          end else if (cnt == CNT_LAST) begin
            state <= S_SPIN;
          end else begin
            cnt <= cnt + 20'd1;
          end
        end
        S_SPIN: begin
          if (!p_s) begin
            state <= S_RELEASE_WAIT;
            cnt   <= 20'd0;
          end
        end
        S_RELEASE_WAIT: begin
          if (p_s) begin
            state <= S_SPIN;
          end else if (cnt == CNT_LAST) begin
            // Results are loaded on entry to DONE so they are valid alongside roll_valid.
            state      <= S_DONE;
            die1       <= s1;
            die2       <= s2;
            sum        <= {1'b0, s1} + {1'b0, s2};
            roll_count <= roll_count + 8'd1;
          end else begin
            cnt <= cnt + 20'd1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign roll_valid = (state == S_DONE);
  assign spinning   = (state == S_SPIN);

endmodule

// File: tb/tb_dice_roller.sv
// tb/tb_dice_roller.sv - randomized self-checking bench for dice_roller
// Model follows DICE_LFSR_EN when the macro is defined for the build.
module tb_dice_roller;

  localparam int DEB = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic       roll_n;
  logic       roll_valid;
  logic [2:0] die1;
  logic [2:0] die2;
  logic [3:0] sum;
  logic       spinning;
  logic [7:0] roll_count;

  dice_roller #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clock      (clock),
    .reset      (reset),
    .roll_n     (roll_n),
    .roll_valid (roll_valid),
    .die1       (die1),
    .die2       (die2),
    .sum        (sum),
    .spinning   (spinning),
    .roll_count (roll_count)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int spin_seen, valid_seen, last_spin, valid_cyc;
  int roll_id = 0;
  logic [2:0] v_d1, v_d2;
  logic [3:0] v_sum;
  logic [7:0] v_cnt;

  // Reference model: die positions, last published values, roll tally, LFSR.
  logic [2:0] m_s1, m_s2, m_d1, m_d2;
  logic [7:0] m_count;
  logic [7:0] m_l;

  task automatic adv(input bit step2);
    if (step2) m_s2 = (m_s2 == 3'd6) ? 3'd1 : m_s2 + 3'd1;
    m_s1 = (m_s1 == 3'd6) ? 3'd1 : m_s1 + 3'd1;
  endtask

  task automatic tick();
    @(negedge clock);
    cyc++;
    if (reset) begin
      m_s1 = 3'd1; m_s2 = 3'd1; m_d1 = 3'd1; m_d2 = 3'd1;
      m_count = 8'd0; m_l = 8'h01;
    end
`ifdef DICE_LFSR_EN
    else begin
      m_l = {m_l[6:0], m_l[7] ^ m_l[5] ^ m_l[4] ^ m_l[3]};
      if (spinning) adv(m_l[0]);
    end
`endif
    if (spinning) begin spin_seen++; last_spin = cyc; end
    if (roll_valid) begin
      valid_seen++; valid_cyc = cyc;
      v_d1 = die1; v_d2 = die2; v_sum = sum; v_cnt = roll_count;
    end
    total++;
    if (die1 < 3'd1 || die1 > 3'd6 || die2 < 3'd1 || die2 > 3'd6 ||
        sum !== ({1'b0, die1} + {1'b0, die2})) begin
      bad++;
      $display("FAIL range cyc=%0d: die1=%0d die2=%0d sum=%0d, required dice in 1..6 and sum=die1+die2",
               cyc, die1, die2, sum);
    end
  endtask

  task automatic do_roll(input int hold, input bit bounce);
    int n;
    roll_id++;
    spin_seen = 0; valid_seen = 0; last_spin = 0; valid_cyc = 0;
    n = hold - DEB + int'(bounce);
    roll_n = 1'b0;
    repeat (hold) tick();
    roll_n = 1'b1;
    if (bounce) begin
      tick(); tick(); roll_n = 1'b0; tick(); roll_n = 1'b1;
    end
    for (int i = 0; i < 64 && valid_seen == 0; i++) tick();
    repeat (4) tick();
`ifndef DICE_LFSR_EN
    repeat (n) adv(m_s1 == 3'd6);
`endif
    m_count++;
    m_d1 = m_s1; m_d2 = m_s2;
    total++;
    if (valid_seen !== 1) begin bad++; $display("FAIL roll%0d pulse_count: got %0d required 1", roll_id, valid_seen); end
    total++;
    if (spin_seen !== n) begin bad++; $display("FAIL roll%0d spin_cycles: got %0d required %0d", roll_id, spin_seen, n); end
    total++;
    if (valid_cyc - last_spin !== DEB + 1) begin
      bad++; $display("FAIL roll%0d pulse_timing: got %0d required %0d", roll_id, valid_cyc - last_spin, DEB + 1);
    end
    total++;
    if (v_d1 !== m_s1) begin bad++; $display("FAIL roll%0d die1: got %0d required %0d", roll_id, v_d1, m_s1); end
    total++;
    if (v_d2 !== m_s2) begin bad++; $display("FAIL roll%0d die2: got %0d required %0d", roll_id, v_d2, m_s2); end
    total++;
    if (v_sum !== {1'b0, m_s1} + {1'b0, m_s2}) begin
      bad++; $display("FAIL roll%0d sum: got %0d required %0d", roll_id, v_sum, m_s1 + m_s2);
    end
    total++;
    if (v_cnt !== m_count) begin bad++; $display("FAIL roll%0d roll_count: got %0d required %0d", roll_id, v_cnt, m_count); end
  endtask

  task automatic check_reset_values(input string tag);
    total++;
    if (die1 !== 3'd1 || die2 !== 3'd1 || sum !== 4'd2 || roll_valid !== 1'b0 ||
        spinning !== 1'b0 || roll_count !== 8'd0) begin
      bad++;
      $display("FAIL %s: die1=%0d die2=%0d sum=%0d valid=%0d spin=%0d count=%0d, required 1 1 2 0 0 0",
               tag, die1, die2, sum, roll_valid, spinning, roll_count);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; roll_n = 1'b1;
    repeat (3) tick();
    check_reset_values("reset_hold");
    #2 reset = 1'b0;
    repeat (3) tick();
    check_reset_values("reset_release");
  endtask

  task automatic test_clean_roll();
    do_roll(DEB + 8, 1'b0);
`ifndef DICE_LFSR_EN
    total++;
    if (v_d1 !== 3'd3 || v_d2 !== 3'd2 || v_sum !== 4'd5 || v_cnt !== 8'd1) begin
      bad++; $display("FAIL clean_roll_const: got %0d %0d %0d %0d required 3 2 5 1", v_d1, v_d2, v_sum, v_cnt);
    end
`endif
  endtask

  task automatic test_glitch();
    spin_seen = 0; valid_seen = 0;
    roll_n = 1'b0;
    repeat (3) tick();
    roll_n = 1'b1;
    repeat (20) tick();
    total++;
    if (spin_seen !== 0 || valid_seen !== 0) begin
      bad++; $display("FAIL glitch_events: spin=%0d valid=%0d required 0 0", spin_seen, valid_seen);
    end
    total++;
    if (die1 !== m_d1 || die2 !== m_d2) begin
      bad++; $display("FAIL glitch_hold: die1=%0d die2=%0d required %0d %0d", die1, die2, m_d1, m_d2);
    end
  endtask

  task automatic test_bounce();
    do_roll(DEB + 3, 1'b1);
  endtask

  task automatic test_reset_mid_spin();
    int waited;
    valid_seen = 0;
    roll_n = 1'b0;
    waited = 0;
    while (spinning !== 1'b1 && waited < 40) begin tick(); waited++; end
    total++;
    if (spinning !== 1'b1) begin bad++; $display("FAIL mid_spin_reach: spinning=%0d required 1", spinning); end
    tick();
    #2 reset = 1'b1;
    #1 check_reset_values("reset_mid_spin");
    roll_n = 1'b1;
    repeat (3) tick();
    #2 reset = 1'b0;
    valid_seen = 0;
    repeat (4) tick();
    total++;
    if (valid_seen !== 0) begin bad++; $display("FAIL reset_no_pulse: got %0d required 0", valid_seen); end
    do_roll(DEB + 1, 1'b0);
`ifndef DICE_LFSR_EN
    total++;
    if (v_d1 !== 3'd2 || v_d2 !== 3'd1 || v_sum !== 4'd3) begin
      bad++; $display("FAIL post_reset_roll: got %0d %0d %0d required 2 1 3", v_d1, v_d2, v_sum);
    end
`endif
  endtask

  task automatic test_random_rolls();
    for (int k = 0; k < 12; k++) begin
      do_roll(DEB + 1 + int'($urandom_range(0, 11)), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_long_spin();
    do_roll(DEB + 1000, 1'b0);
  endtask

  task automatic test_back_to_back_wrap();
    #2 reset = 1'b1;
    repeat (2) tick();
    #2 reset = 1'b0;
    tick();
    for (int k = 0; k < 256; k++) begin
      do_roll(DEB + 1 + int'($urandom_range(0, 3)), 1'b0);
    end
    total++;
    if (roll_count !== 8'd0) begin bad++; $display("FAIL wrap_count: got %0d required 0", roll_count); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_clean_roll();
    test_glitch();
    test_bounce();
    test_reset_mid_spin();
    test_random_rolls();
    test_long_spin();
    test_back_to_back_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dice_roller.md
Name: dice_roller

Overview:
- Upstream stage of the dice game FSM; takes the raw active-low roll pushbutton and produces a debounced roll event carrying two die values.
- Replaces the bare button inversion at the top level with a synchronizer, a debounce state machine and two spinning mod-6 die counters.
- Dice spin while the button is held and are latched on a debounced release.
- The FSM consumes `roll_valid`, `die1`, `die2` and `sum`.

Parameters:
- DEBOUNCE_CYCLES, 500000, stable cycles required to accept a press or release (10 ms at 50 MHz); legal range 1..2^20-1.

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- roll_n  input  1  raw pushbutton, low = pressed, asynchronous to clock
- roll_valid  output  1  one-cycle pulse, new die values valid
- die1  output  3  last rolled value of die 1, range 1..6
- die2  output  3  last rolled value of die 2, range 1..6
- sum  output  4  die1+die2, range 2..12
- spinning  output  1  high while the state is SPIN
- roll_count  output  8  number of completed rolls, wraps 255->0

Behaviour:
- Reset (async, active-high):
  - state=IDLE; sync flops=0; debounce counter=0.
  - Spin counters s1=1, s2=1.
  - Outputs: die1=1, die2=1, sum=2, roll_valid=0, spinning=0, roll_count=0.
- Synchronizer: p = ~roll_n through 2 flops (p_s). FSM acts on p_s only; 2-cycle input latency.
- States:
  - IDLE:
    - p_s=1 -> PRESS_WAIT, cnt=0.
  - PRESS_WAIT:
    - p_s=0 -> IDLE (glitch rejected).
    - Otherwise cnt++; when cnt==DEBOUNCE_CYCLES-1 -> SPIN.
  - SPIN:
    - spinning=1.
    - Every cycle s1 advances 1->2->...->6->1.
    - s2 advances by one in the same cycle s1 wraps 6->1.
    - p_s=0 -> RELEASE_WAIT, cnt=0. s1/s2 still advance in this cycle.
  - RELEASE_WAIT:
    - s1/s2 frozen.
    - p_s=1 -> SPIN (release bounce; spinning resumes, no roll).
    - Otherwise cnt++; when cnt==DEBOUNCE_CYCLES-1 -> DONE.
  - DONE:
    - Registered die1<=s1, die2<=s2, sum<=s1+s2 (4-bit, no overflow).
    - roll_valid=1 for exactly this cycle.
    - roll_count increments, wrapping modulo 256.
    - -> IDLE unconditionally.
    - A press already asserted on p_s is seen in IDLE on the next cycle.
- Output hold: die1/die2/sum change only in DONE and hold between rolls.
- Spin state: s1/s2 are not reset between rolls; spin continues from the previous values.
- Debounce counter: 20 bits.
- DEBOUNCE_CYCLES=1: PRESS_WAIT and RELEASE_WAIT each last exactly one cycle.
- Reset mid-operation (any state, including DONE): immediate return to the reset values; no roll_valid pulse is emitted.
- Die values 0 or 7 must never appear on any output or internal spin counter.

Optional Feature:
- Macro: DICE_LFSR_EN.
- Defined:
  - Adds an 8-bit LFSR, polynomial x^8+x^6+x^5+x^4+1, Fibonacci form, shifts left every clock in all states.
  - New bit = l[7]^l[5]^l[4]^l[3]; reset seed 8'h01.
  - In SPIN, s2 advances when l[0]==1 instead of on the s1 wrap; s1 is unchanged.
  - This decorrelates the two dice.
- Undefined:
  - No LFSR logic is present.
  - s2 advances on the s1 wrap exactly as specified above.

Test Plan (DEBOUNCE_CYCLES=4, macro undefined unless stated):
- Reset check: assert reset mid-clock -> immediately die1=1, die2=1, sum=2, roll_valid=0, spinning=0, roll_count=0.
- Glitch rejection:
  - Stimulus: roll_n low 3 cycles, then high 20 cycles.
  - Required: state returns to IDLE; no roll_valid; spinning never high; die outputs unchanged.
- Clean roll:
  - Stimulus: from reset, hold press so exactly 8 cycles are spent in SPIN, then release cleanly.
  - Required: one roll_valid pulse; die1=3, die2=2, sum=5, roll_count=1.
  - Pulse timing: asserted 4 cycles after leaving SPIN.
- Release bounce:
  - Stimulus: during RELEASE_WAIT, roll_n goes low for 1 synchronized cycle.
  - Required: returns to SPIN, spinning=1, no roll_valid; after the final clean release, exactly one pulse.
- Reset mid-SPIN:
  - Stimulus: assert reset while spinning=1.
  - Required: spinning=0 immediately; die outputs=1/1; no pulse.
  - Next clean roll with 1 cycle in SPIN gives die1=2, die2=1, sum=3.
- Wrap and feature:
  - 256 rolls -> roll_count reads 0 after the 256th.
  - With DICE_LFSR_EN: compare s2 against a reference LFSR model over 1000 SPIN cycles; all die values stay in 1..6.
